quad_enc_ctrl: RTL and testbench
================================

# quad_enc_ctrl

Parametrised quadrature encoder controller for the peripheral unit. Synchronises and glitch-filters the A/B/index pins, decodes X4 quadrature into a COUNT_W-bit up/down position with optional modulo wrap, and flags illegal transitions. It also provides a threshold-match interrupt, an index latch/clear, and an abortable index-calibration FSM. An optional windowed velocity measurement can be compiled in.

## Interface
- COUNT_W, 32: position, threshold and modulo width (8..32).
- SYNC_STAGES, 2: pin synchroniser flops (≥2).
- FILT_LEN, 3: consecutive stable synced samples required before a pin change is accepted; 0 = filter bypassed.
- VEL_W, 16: signed velocity width.
- VEL_WIN, 1000: velocity window length in clk_i cycles (≥2).
---
- clk_i  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- quad_a_i, quad_b_i, index_i  in  1 each  raw encoder pins, asynchronous.
- count_wr, thresh_wr, modulo_wr, cr_wr  in  1 each  write strobes; the action fires once per rising edge.
- count_i, thresh_i, modulo_i  in  COUNT_W each  write data.
- cr_i  in  4  control: [0] index latch enable, [1] index clears count, [2] direction invert, [3] calibration start.
- calib_motor_stopped  in  1  motor-stopped acknowledge (level).
- count  out  COUNT_W  current position.
- latched_count  out  COUNT_W  count captured at the last accepted index.
- dir_o  out  1  direction of the last step (1 = up).
- thresh_irq, index_irq, err_irq, calib_finished  out  1 each  one-cycle pulses.
- calib_stop_motor, calib_busy  out  1 each  levels.
- velocity  out  VEL_W  signed steps per window.

## Operation
- **Reset values:**
  - Every output is 0.
  - Internal threshold register is all-ones; modulo and control registers are 0; FSM is IDLE.
  - Filtered pin state loads from 0.
- **Write strobes:**
  - Each strobe passes through a 2-flop edge detector, so the action occurs exactly once per 0→1 transition.
  - Holding a strobe high causes no repeat.
  - The data input is sampled on the detected cycle.
- **Filter:** the filtered pin takes the synced value only after that value has differed from the current filtered value for FILT_LEN consecutive cycles. Any bounce restarts the run counter.
- **X4 decode** on filtered A/B, compared against the previous filtered A/B:
  - One input changed: one step. Up when newA ^ oldB = 1.
  - cr_i[2] inverts the direction.
  - Both inputs changed in the same cycle: err_irq is pulsed and count is unchanged.
- **Modulo** (M = modulo register):
  - M = 0: natural 2^COUNT_W wrap.
  - M ≠ 0, counting up: M-1 → 0.
  - M ≠ 0, counting down: 0 → M-1.
  - count_wr / index-clear values ≥ M are reduced to value mod M only if the team later requires it; here they are loaded as-is and wrap on the next step.
- **Count update priority** (highest first): calibration SET_POS load, count_wr, index clear (cr_i[1]), step. A step coincident with a higher-priority load is dropped.
- **Index** (rising edge of filtered index):
  - Only acted on when cr_i[0] = 1 and the FSM is IDLE.
  - Latches latched_count ← count (value before any same-cycle step) and pulses index_irq.
  - With cr_i[1] = 1, also clears count to 0.
- **Threshold:**
  - thresh_irq pulses on the cycle after count becomes equal to the threshold from a different value.
  - It does not re-pulse while count stays equal.
  - A thresh_wr to the current count value pulses once.
- **Calibration FSM:**
  - IDLE → FIND_INDEX on detected cr_wr with cr_i[3] = 1; calib_busy = 1 outside IDLE.
  - FIND_INDEX → WAIT_STOP on index edge: latched_count ← count, index_irq, calib_stop_motor = 1 (held until IDLE).
  - WAIT_STOP → SET_POS when calib_motor_stopped = 1.
  - SET_POS: count ← count − latched_count (mod 2^COUNT_W, then the modulo rule); → IDLE with a calib_finished pulse.
  - Abort: detected cr_wr with cr_i[3] = 0 in any non-IDLE state → IDLE; no calib_finished, calib_stop_motor is released.
  - cr_wr with cr_i[3] = 1 while busy is ignored for bit 3; bits [2:0] are always written.
- **Reset mid-operation:** all state returns to the reset values immediately; no pulses are emitted.

## Timing
- **Pin to count latency:** SYNC_STAGES + FILT_LEN + 1 cycles. With the defaults that is 6.
- **Minimum resolvable step spacing:** FILT_LEN + 1 cycles per edge.
- **Write latency:** count_wr to count: 3 cycles after the strobe rises (2 detector flops + 1 register). thresh_wr and modulo_wr take effect on the same schedule.
- **Interrupt timing:**
  - index_irq and latched_count update 1 cycle after the filtered index rises.
  - thresh_irq asserts 1 cycle after the count match.
- **calib_motor_stopped:** registered once, so there is 1 cycle from its assertion to SET_POS, and count loads plus calib_finished pulses in the cycle after that.

## Configuration
- **QENC_VELOCITY_EN defined:**
  - A free-running window counter counts 0..VEL_WIN-1.
  - A signed accumulator adds +1 per up step and −1 per down step, saturating at the ±(2^(VEL_W-1)-1) limits.
  - At window end the accumulator is copied to velocity and cleared.
  - Loads and errors do not contribute.
- **Not defined:** velocity is tied to 0 and no window/accumulator logic is synthesised.

## Test plan
- **Up-count:** FILT_LEN=3; drive 8 clean A-leads-B edges spaced 10 cycles apart → count = 8, dir_o = 1, first change 6 cycles after the first edge.
- **Glitch rejection and illegal transition:**
  - A 2-cycle pulse on A → no count change.
  - Toggle A and B simultaneously → err_irq is a 1-cycle pulse and count is unchanged.
- **Modulo wrap:**
  - modulo = 100, count_wr 99, one up step → 0.
  - Then one down step → 99.
- **Threshold:** thresh = 5, count up 0→7 → exactly one thresh_irq pulse, 1 cycle after count = 5; reverse back through 5 → a second single pulse.
- **Calibration:**
  - Start with count = 40; index at count = 40, drive 3 more steps, assert calib_motor_stopped → count = 3, one calib_finished pulse, calib_stop_motor drops.
  - Repeat the run but abort in WAIT_STOP → no calib_finished pulse, count unchanged.
- **Velocity** (QENC_VELOCITY_EN, VEL_WIN = 100): 10 up steps inside one window → velocity = 10 at window end; drive reset_n low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/quad_enc_ctrl.sv
// Quadrature encoder controller: pin sync/filter, X4 decode, modulo position, index latch,
// threshold interrupt and index calibration FSM. Define QENC_VELOCITY_EN for windowed velocity.

module qenc_pin_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic pin_i,
    output logic filt_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign filt_o = sync_q[SYNC_STAGES-1];
        end else begin : g_filt
            localparam int RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            logic [RW-1:0] run_q;
            logic          filt_q;

            // A change is accepted on the FILT_LEN-th consecutive differing sample.
            always_ff @(posedge clk_i or negedge reset_n) begin
                if (!reset_n) begin
                    run_q  <= '0;
                    filt_q <= 1'b0;
                end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    run_q <= '0;
                end else if (run_q == RW'(FILT_LEN - 1)) begin
                    filt_q <= sync_q[SYNC_STAGES-1];
                    run_q  <= '0;
                end else begin
                    run_q <= run_q + 1'b1;
                end
            end
            assign filt_o = filt_q;
        end
    endgenerate
endmodule

module quad_enc_ctrl #(
    parameter int COUNT_W     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int VEL_W       = 16,
    parameter int VEL_WIN     = 1000
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic                     quad_a_i,
    input  logic                     quad_b_i,
    input  logic                     index_i,
    input  logic                     count_wr,
    input  logic                     thresh_wr,
    input  logic                     modulo_wr,
    input  logic                     cr_wr,
    input  logic [COUNT_W-1:0]       count_i,
    input  logic [COUNT_W-1:0]       thresh_i,
    input  logic [COUNT_W-1:0]       modulo_i,
    input  logic [3:0]               cr_i,
    input  logic                     calib_motor_stopped,
    output logic [COUNT_W-1:0]       count,
    output logic [COUNT_W-1:0]       latched_count,
    output logic                     dir_o,
    output logic                     thresh_irq,
    output logic                     index_irq,
    output logic                     err_irq,
    output logic                     calib_finished,
    output logic                     calib_stop_motor,
    output logic                     calib_busy,
    output logic signed [VEL_W-1:0]  velocity
);
    typedef enum logic [1:0] {ST_IDLE, ST_FIND_INDEX, ST_WAIT_STOP, ST_SET_POS} calib_state_e;

    logic [2:0] pin_raw, filt;
    assign pin_raw = {index_i, quad_b_i, quad_a_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pin
            qenc_pin_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_pin (
                .clk_i   (clk_i),
                .reset_n (reset_n),
                .pin_i   (pin_raw[gi]),
                .filt_o  (filt[gi])
            );
        end
    endgenerate

    // Strobe order: {cr, modulo, thresh, count}
    logic [3:0] wr_vec, stb1_q, stb2_q, det_q;
    assign wr_vec = {cr_wr, modulo_wr, thresh_wr, count_wr};

    logic [1:0]          ab_prev_q;
    logic                idx_prev_q;
    logic [COUNT_W-1:0]  count_q, count_d, latched_q, thresh_q, modulo_q;
    logic [2:0]          cr_q;
    logic                dir_q, eq_q, ms_q;
    logic                thr_irq_q, idx_irq_q, err_irq_q, fin_q;
    calib_state_e        state_q, state_d;

    logic a_chg, b_chg, step, both_chg, step_up, idx_rise;
    logic abort, calib_load, calib_latch, idle_idx, latch_evt, idx_clear, cnt_eq;
    logic [COUNT_W-1:0] m_last, cnt_step, calib_val;

    assign a_chg    = filt[0] ^ ab_prev_q[0];
    assign b_chg    = filt[1] ^ ab_prev_q[1];
    assign step     = a_chg ^ b_chg;
    assign both_chg = a_chg & b_chg;
    assign step_up  = (filt[0] ^ ab_prev_q[1]) ^ cr_q[2];
    assign idx_rise = filt[2] & ~idx_prev_q;

    assign abort       = det_q[3] && !cr_i[3] && (state_q != ST_IDLE);
    assign calib_load  = (state_q == ST_SET_POS) && !abort;
    assign calib_latch = (state_q == ST_FIND_INDEX) && idx_rise && !abort;
    assign idle_idx    = (state_q == ST_IDLE) && idx_rise && cr_q[0];
    assign latch_evt   = idle_idx | calib_latch;
    assign idx_clear   = idle_idx & cr_q[1];
    assign cnt_eq      = (count_q == thresh_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (det_q[3] && cr_i[3]) state_d = ST_FIND_INDEX;
            ST_FIND_INDEX: if (abort) state_d = ST_IDLE;
                           else if (idx_rise) state_d = ST_WAIT_STOP;
            ST_WAIT_STOP:  if (abort) state_d = ST_IDLE;
                           else if (ms_q) state_d = ST_SET_POS;
            ST_SET_POS:    state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Out-of-range values (>= modulo) wrap to the nearest end on their next step.
    always_comb begin
        m_last   = modulo_q - 1'b1;
        cnt_step = count_q;
        if (step_up) begin
            if (modulo_q != '0 && count_q >= m_last) cnt_step = '0;
            else                                     cnt_step = count_q + 1'b1;
        end else begin
            if (modulo_q != '0 && (count_q == '0 || count_q > m_last)) cnt_step = m_last;
            else                                                       cnt_step = count_q - 1'b1;
        end

        calib_val = count_q - latched_q;
        if (modulo_q != '0 && count_q < latched_q)
            calib_val = count_q + modulo_q - latched_q;

        count_d = count_q;
        if (calib_load)      count_d = calib_val;
        else if (det_q[0])   count_d = count_i;
        else if (idx_clear)  count_d = '0;
        else if (step)       count_d = cnt_step;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            stb1_q     <= '0;
            stb2_q     <= '0;
            det_q      <= '0;
            ab_prev_q  <= '0;
            idx_prev_q <= 1'b0;
            count_q    <= '0;
            latched_q  <= '0;
            thresh_q   <= '1;
            modulo_q   <= '0;
            cr_q       <= '0;
            dir_q      <= 1'b0;
            eq_q       <= 1'b0;
            ms_q       <= 1'b0;
            thr_irq_q  <= 1'b0;
            idx_irq_q  <= 1'b0;
            err_irq_q  <= 1'b0;
            fin_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            stb1_q     <= wr_vec;
            stb2_q     <= stb1_q;
            det_q      <= stb1_q & ~stb2_q;
            ab_prev_q  <= filt[1:0];
            idx_prev_q <= filt[2];
            count_q    <= count_d;
            if (latch_evt) latched_q <= count_q;
            if (det_q[1])  thresh_q  <= thresh_i;
            if (det_q[2])  modulo_q  <= modulo_i;
            if (det_q[3])  cr_q      <= cr_i[2:0];
            if (step)      dir_q     <= step_up;
            eq_q       <= cnt_eq;
            ms_q       <= calib_motor_stopped;
            thr_irq_q  <= cnt_eq & ~eq_q;
            idx_irq_q  <= latch_evt;
            err_irq_q  <= both_chg;
            fin_q      <= calib_load;
            state_q    <= state_d;
        end
    end

    assign count            = count_q;
    assign latched_count    = latched_q;
    assign dir_o            = dir_q;
    assign thresh_irq       = thr_irq_q;
    assign index_irq        = idx_irq_q;
    assign err_irq          = err_irq_q;
    assign calib_finished   = fin_q;
    assign calib_busy       = (state_q != ST_IDLE);
    assign calib_stop_motor = (state_q == ST_WAIT_STOP) || (state_q == ST_SET_POS);

`ifdef QENC_VELOCITY_EN
    localparam int WW = $clog2(VEL_WIN);
    localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VMIN = -VMAX;

    logic [WW-1:0]            win_q;
    logic signed [VEL_W-1:0]  acc_q, acc_d, vel_q;
    logic                     step_applied;

    // Only steps that actually moved the count contribute.
    assign step_applied = step && !calib_load && !det_q[0] && !idx_clear;

    always_comb begin
        acc_d = acc_q;
        if (step_applied) begin
            if (step_up && acc_q != VMAX)       acc_d = acc_q + VEL_W'(1);
            else if (!step_up && acc_q != VMIN) acc_d = acc_q - VEL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            win_q <= '0;
            acc_q <= '0;
            vel_q <= '0;
        end else if (win_q == WW'(VEL_WIN - 1)) begin
            win_q <= '0;
            acc_q <= '0;
            vel_q <= acc_d;
        end else begin
            win_q <= win_q + 1'b1;
            acc_q <= acc_d;
        end
    end

    assign velocity = vel_q;
`else
    assign velocity = '0;
`endif
endmodule

// File: tb/tb_quad_enc_ctrl.sv
// Bench for quad_enc_ctrl: vector table, directed corner sequences and a randomized
// position run checked against an arithmetic reference.

module tb_quad_enc_ctrl;
    localparam int K_UP = 0, K_DN = 1, K_WCNT = 2, K_WMOD = 3, K_WCR = 4, K_WTHR = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
        logic [31:0] exp_cnt;
        logic        exp_dir;
    } vec_t;

    logic clk_i, reset_n;
    logic quad_a_i, quad_b_i, index_i;
    logic count_wr, thresh_wr, modulo_wr, cr_wr;
    logic [31:0] count_i, thresh_i, modulo_i;
    logic [3:0]  cr_i;
    logic calib_motor_stopped;
    logic [31:0] count, latched_count;
    logic dir_o, thresh_irq, index_irq, err_irq, calib_finished, calib_stop_motor, calib_busy;
    logic [15:0] velocity;

    quad_enc_ctrl #(.COUNT_W(32), .SYNC_STAGES(2), .FILT_LEN(3), .VEL_W(16), .VEL_WIN(100)) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .quad_a_i(quad_a_i), .quad_b_i(quad_b_i), .index_i(index_i),
        .count_wr(count_wr), .thresh_wr(thresh_wr), .modulo_wr(modulo_wr), .cr_wr(cr_wr),
        .count_i(count_i), .thresh_i(thresh_i), .modulo_i(modulo_i), .cr_i(cr_i),
        .calib_motor_stopped(calib_motor_stopped),
        .count(count), .latched_count(latched_count), .dir_o(dir_o),
        .thresh_irq(thresh_irq), .index_irq(index_irq), .err_irq(err_irq),
        .calib_finished(calib_finished), .calib_stop_motor(calib_stop_motor),
        .calib_busy(calib_busy), .velocity(velocity)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;
    int n_thr = 0, n_idx = 0, n_err = 0, n_fin = 0, thr_bad = 0;
    logic        thr_chk_en = 1'b0;
    logic [31:0] exp_thresh = '1;
    logic [31:0] cnt_d1 = '0, cnt_d2 = '0;
    logic [1:0]  gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int          ph = 0;
    vec_t        tbl [14];

    // Pulse monitor; threshold pulses are also timed against the count history.
    always @(negedge clk_i) begin
        if (thresh_irq) begin
            n_thr <= n_thr + 1;
            if (thr_chk_en && !(cnt_d1 == exp_thresh && cnt_d2 != exp_thresh)) thr_bad <= thr_bad + 1;
        end
        if (index_irq)      n_idx <= n_idx + 1;
        if (err_irq)        n_err <= n_err + 1;
        if (calib_finished) n_fin <= n_fin + 1;
        cnt_d2 <= cnt_d1;
        cnt_d1 <= count;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {quad_a_i, quad_b_i, index_i} = '0;
        {count_wr, thresh_wr, modulo_wr, cr_wr} = '0;
        count_i = '0; thresh_i = '0; modulo_i = '0; cr_i = '0;
        calib_motor_stopped = 1'b0;
        ph = 0;
        exp_thresh = '1;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic step(input bit up, input int sp);
        ph = up ? ((ph + 1) & 3) : ((ph + 3) & 3);
        {quad_a_i, quad_b_i} = gray[ph];
        cyc(sp);
    endtask

    task automatic wr(input int kind, input logic [31:0] v);
        case (kind)
            K_WCNT: begin count_i  = v; count_wr  = 1'b1; end
            K_WTHR: begin thresh_i = v; thresh_wr = 1'b1; exp_thresh = v; end
            K_WMOD: begin modulo_i = v; modulo_wr = 1'b1; end
            default: begin cr_i = v[3:0]; cr_wr = 1'b1; end
        endcase
        cyc(4);
        {count_wr, thresh_wr, modulo_wr, cr_wr} = '0;
        cyc(2);
    endtask

    task automatic index_pulse();
        index_i = 1'b1;
        cyc(8);
        index_i = 1'b0;
        cyc(8);
    endtask

    initial begin
        int base;
        logic [31:0] mcnt, mm;
        tbl[0]  = '{K_WCNT, 32'd10, 32'd10,         1'b0};
        tbl[1]  = '{K_UP,   32'd0,  32'd11,         1'b1};
        tbl[2]  = '{K_DN,   32'd0,  32'd10,         1'b0};
        tbl[3]  = '{K_WCNT, 32'd0,  32'd0,          1'b0};
        tbl[4]  = '{K_DN,   32'd0,  32'hFFFF_FFFF,  1'b0};
        tbl[5]  = '{K_UP,   32'd0,  32'd0,          1'b1};
        tbl[6]  = '{K_WMOD, 32'd100, 32'd0,         1'b0};
        tbl[7]  = '{K_WCNT, 32'd99, 32'd99,         1'b0};
        tbl[8]  = '{K_UP,   32'd0,  32'd0,          1'b1};
        tbl[9]  = '{K_DN,   32'd0,  32'd99,         1'b0};
        tbl[10] = '{K_WCR,  32'd4,  32'd99,         1'b0};
        tbl[11] = '{K_UP,   32'd0,  32'd98,         1'b0};
        tbl[12] = '{K_WCR,  32'd0,  32'd98,         1'b0};
        tbl[13] = '{K_WMOD, 32'd0,  32'd98,         1'b0};

        do_reset();
        chk("rst_count", count, 0);
        chk("rst_latched", latched_count, 0);
        chk("rst_dir", dir_o, 0);
        chk("rst_thresh_irq", thresh_irq, 0);
        chk("rst_index_irq", index_irq, 0);
        chk("rst_err_irq", err_irq, 0);
        chk("rst_calib_fin", calib_finished, 0);
        chk("rst_stop_motor", calib_stop_motor, 0);
        chk("rst_busy", calib_busy, 0);
        chk("rst_velocity", velocity, 0);

        // Up-count with first-edge latency
        step(1'b1, 5);
        chk("lat_before", count, 0);
        cyc(1);
        chk("lat_at6", count, 1);
        cyc(4);
        for (int i = 0; i < 7; i++) step(1'b1, 10);
        chk("upcount", count, 8);
        chk("upcount_dir", dir_o, 1);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].kind == K_UP || tbl[i].kind == K_DN) begin
                step(tbl[i].kind == K_UP, 10);
                chk($sformatf("tbl%0d_dir", i), dir_o, tbl[i].exp_dir);
            end else begin
                wr(tbl[i].kind, tbl[i].val);
            end
            chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
        end

        // Glitch rejection and illegal transition
        do_reset();
        step(1'b1, 10);
        step(1'b1, 10);
        base = n_err;
        {quad_a_i, quad_b_i} = gray[ph] ^ 2'b10;
        cyc(2);
        {quad_a_i, quad_b_i} = gray[ph];
        cyc(12);
        chk("glitch_count", count, 2);
        ph = (ph + 2) & 3;
        {quad_a_i, quad_b_i} = gray[ph];
        cyc(12);
        chk("err_pulses", n_err - base, 1);
        chk("err_count", count, 2);

        // Threshold
        do_reset();
        wr(K_WTHR, 32'd5);
        base = n_thr;
        thr_chk_en = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 10);
        chk("thr_up_count", count, 7);
        chk("thr_up_pulses", n_thr - base, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 10);
        chk("thr_dn_count", count, 4);
        chk("thr_dn_pulses", n_thr - base, 2);
        chk("thr_timing", thr_bad, 0);
        thr_chk_en = 1'b0;
        wr(K_WTHR, 32'd4);
        chk("thr_wr_eq_pulses", n_thr - base, 3);

        // Index latch and clear in IDLE
        do_reset();
        wr(K_WCR, 32'd3);
        wr(K_WCNT, 32'd20);
        base = n_idx;
        index_pulse();
        chk("idx_latched", latched_count, 20);
        chk("idx_clear", count, 0);
        chk("idx_pulses", n_idx - base, 1);
        wr(K_WCR, 32'd0);
        wr(K_WCNT, 32'd7);
        index_pulse();
        chk("idx_dis_latched", latched_count, 20);
        chk("idx_dis_count", count, 7);

        // Calibration run
        do_reset();
        wr(K_WCNT, 32'd40);
        base = n_fin;
        wr(K_WCR, 32'd8);
        chk("cal_busy", calib_busy, 1);
        chk("cal_stop_early", calib_stop_motor, 0);
        index_pulse();
        chk("cal_stop", calib_stop_motor, 1);
        chk("cal_latched", latched_count, 40);
        for (int i = 0; i < 3; i++) step(1'b1, 10);
        chk("cal_pre_count", count, 43);
        calib_motor_stopped = 1'b1;
        for (int i = 0; i < 30 && calib_busy; i++) cyc(1);
        chk("cal_done_busy", calib_busy, 0);
        cyc(2);
        calib_motor_stopped = 1'b0;
        chk("cal_count", count, 3);
        chk("cal_fin_pulses", n_fin - base, 1);
        chk("cal_stop_release", calib_stop_motor, 0);

        // Calibration abort in WAIT_STOP
        do_reset();
        wr(K_WCNT, 32'd40);
        base = n_fin;
        wr(K_WCR, 32'd8);
        index_pulse();
        for (int i = 0; i < 3; i++) step(1'b1, 10);
        chk("abort_stop_pre", calib_stop_motor, 1);
        wr(K_WCR, 32'd0);
        chk("abort_busy", calib_busy, 0);
        chk("abort_stop", calib_stop_motor, 0);
        calib_motor_stopped = 1'b1;
        cyc(10);
        calib_motor_stopped = 1'b0;
        chk("abort_count", count, 43);
        chk("abort_fin_pulses", n_fin - base, 0);

        // Randomized position run against arithmetic reference
        do_reset();
        mm = ($urandom % 2 == 0) ? 32'd0 : $urandom_range(50, 200);
        if (mm != 0) wr(K_WMOD, mm);
        mcnt = '0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom % 10 < 7) begin
                bit up;
                up = $urandom % 2;
                if (up) mcnt = (mm != 0) ? (mcnt + 1) % mm : mcnt + 1;
                else    mcnt = (mm != 0) ? ((mcnt == 0) ? mm - 1 : mcnt - 1) : mcnt - 1;
                step(up, 8);
                chk($sformatf("rnd%0d_dir", i), dir_o, up);
            end else begin
                mcnt = (mm != 0) ? $urandom % mm : $urandom;
                wr(K_WCNT, mcnt);
            end
            chk($sformatf("rnd%0d_count", i), count, mcnt);
        end

        // Velocity window, then reset mid-window
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 6);
`ifdef QENC_VELOCITY_EN
        for (int i = 0; i < 200 && velocity == 0; i++) cyc(1);
        chk("velocity", velocity, 10);
`else
        cyc(60);
        chk("velocity_off", velocity, 0);
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 6);
        chk("pre_rst_count", count, 13);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_dir", dir_o, 0);
        chk("midrst_velocity", velocity, 0);
        chk("midrst_busy", calib_busy, 0);
        chk("midrst_irqs", {thresh_irq, index_irq, err_irq, calib_finished}, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
